// File: rtl/unstriping_sched.sv
// unstriping_sched: two-lane un-striping scheduler. Buffers lane_0/lane_1 words in
// per-lane FIFOs, aligns the lanes, then drains them alternately (lane 0 first)
// onto one output stream at clk_2f. Flags lane overflow and re-syncs after a stall.
// Optional feature macro: UNSTRIPE_ERR_CNT_EN adds a saturating err_cnt[7:0] output.
module unstriping_sched #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned STALL_MAX  = 8
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic [WIDTH-1:0] lane_0,
  input  logic             valid_0,
  input  logic [WIDTH-1:0] lane_1,
  input  logic             valid_1,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             next_lane,
  output logic             ovf_0,
  output logic             ovf_1,
  output logic             sync_err
`ifdef UNSTRIPE_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned SW    = $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_RUN_L0 = 2'd1,
    ST_RUN_L1 = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [WIDTH-1:0]      mem_0 [DEPTH];
  logic [WIDTH-1:0]      mem_1 [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_0, rd_ptr_0, wr_ptr_1, rd_ptr_1;
  logic [CW-1:0]         cnt_0, cnt_1;
  logic [SW-1:0]         stall_cnt, stall_cnt_nxt, stall_inc;
  logic                  empty_0, empty_1, full_0, full_1;
  logic                  wr_0, wr_1, drop_0, drop_1;
  logic                  pop_0, pop_1, timeout;

  assign empty_0   = (cnt_0 == '0);
  assign empty_1   = (cnt_1 == '0);
  assign full_0    = (cnt_0 == CW'(DEPTH));
  assign full_1    = (cnt_1 == CW'(DEPTH));
  // A full FIFO refuses the write even when it is popped in the same cycle.
  assign wr_0      = valid_0 && !full_0;
  assign wr_1      = valid_1 && !full_1;
  assign drop_0    = valid_0 && full_0;
  assign drop_1    = valid_1 && full_1;
  assign stall_inc = (stall_cnt == SW'(STALL_MAX)) ? stall_cnt : stall_cnt + SW'(1);

  // FIFO storage; contents are qualified by the pointers, so no reset is needed.
  always_ff @(posedge clk_2f) begin
    if (wr_0) mem_0[wr_ptr_0] <= lane_0;
    if (wr_1) mem_1[wr_ptr_1] <= lane_1;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      wr_ptr_0 <= '0;
      rd_ptr_0 <= '0;
      wr_ptr_1 <= '0;
      rd_ptr_1 <= '0;
      cnt_0    <= '0;
      cnt_1    <= '0;
    end else begin
      if (wr_0)  wr_ptr_0 <= wr_ptr_0 + DEPTH_LOG2'(1);
      if (pop_0) rd_ptr_0 <= rd_ptr_0 + DEPTH_LOG2'(1);
      if (wr_1)  wr_ptr_1 <= wr_ptr_1 + DEPTH_LOG2'(1);
      if (pop_1) rd_ptr_1 <= rd_ptr_1 + DEPTH_LOG2'(1);
      cnt_0 <= cnt_0 + CW'(wr_0) - CW'(pop_0);
      cnt_1 <= cnt_1 + CW'(wr_1) - CW'(pop_1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_2f) begin
    if (!reset) state <= ST_SYNC;
    else        state <= state_nxt;
  end

  // Next state: align in SYNC, alternate lanes in RUN, fall back to SYNC on timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_SYNC:   if (!empty_0 && !empty_1) state_nxt = ST_RUN_L0;
      ST_RUN_L0: begin
        if (pop_0)        state_nxt = ST_RUN_L1;
        else if (timeout) state_nxt = ST_SYNC;
      end
      ST_RUN_L1: begin
        if (pop_1)        state_nxt = ST_RUN_L0;
        else if (timeout) state_nxt = ST_SYNC;
      end
      default:   state_nxt = ST_SYNC;
    endcase
  end

  // Pop decisions and stall tracking for the current state.
  always_comb begin
    pop_0         = 1'b0;
    pop_1         = 1'b0;
    timeout       = 1'b0;
    stall_cnt_nxt = '0;
    case (state)
      ST_RUN_L0: begin
        if (!empty_0) begin
          pop_0 = 1'b1;
        end else if (stall_inc == SW'(STALL_MAX)) begin
          timeout = 1'b1;
        end else begin
          stall_cnt_nxt = stall_inc;
        end
      end
      ST_RUN_L1: begin
        if (!empty_1) begin
          pop_1 = 1'b1;
        end else if (stall_inc == SW'(STALL_MAX)) begin
          timeout = 1'b1;
        end else begin
          stall_cnt_nxt = stall_inc;
        end
      end
      default: stall_cnt_nxt = '0;
    endcase
  end

  // Registered outputs and stall counter; data_out holds when nothing is popped.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      next_lane <= 1'b0;
      ovf_0     <= 1'b0;
      ovf_1     <= 1'b0;
      sync_err  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (pop_0)      data_out <= mem_0[rd_ptr_0];
      else if (pop_1) data_out <= mem_1[rd_ptr_1];
      valid_out <= pop_0 || pop_1;
      next_lane <= (state_nxt == ST_RUN_L1);
      ovf_0     <= ovf_0 || drop_0;
      ovf_1     <= ovf_1 || drop_1;
      sync_err  <= timeout;
      stall_cnt <= stall_cnt_nxt;
    end
  end

`ifdef UNSTRIPE_ERR_CNT_EN
  logic [8:0] err_sum;
  assign err_sum = 9'(err_cnt) + 9'(drop_0) + 9'(drop_1) + 9'(timeout);

  // Saturating count of dropped words and stall re-syncs.
  always_ff @(posedge clk_2f) begin
    if (!reset)                err_cnt <= '0;
    else if (err_sum > 9'd255) err_cnt <= 8'hFF;
    else                       err_cnt <= err_sum[7:0];
  end
`endif

endmodule

// File: tb/tb_unstriping_sched.sv
// Testbench for unstriping_sched: directed scenarios followed by randomized traffic,
// checked against a queue-based reference model with a decoupled output monitor.
module tb_unstriping_sched;

  localparam int W         = 32;
  localparam int DEPTH     = 4;
  localparam int STALL_MAX = 8;

  logic         clk_2f = 1'b0;
  logic         reset;
  logic [W-1:0] lane_0, lane_1;
  logic         valid_0, valid_1;
  logic [W-1:0] data_out;
  logic         valid_out, next_lane, ovf_0, ovf_1, sync_err;
`ifdef UNSTRIPE_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_2f = ~clk_2f;

  unstriping_sched #(.WIDTH(W), .DEPTH_LOG2(2), .STALL_MAX(STALL_MAX)) dut (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .lane_0   (lane_0),
    .valid_0  (valid_0),
    .lane_1   (lane_1),
    .valid_1  (valid_1),
    .data_out (data_out),
    .valid_out(valid_out),
    .next_lane(next_lane),
    .ovf_0    (ovf_0),
    .ovf_1    (ovf_1),
    .sync_err (sync_err)
`ifdef UNSTRIPE_ERR_CNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  // Reference model state: lane buffers as queues, the lane whose turn it is
  // (-1 while waiting for both lanes to have data), and expected flag values.
  logic [W-1:0] m_q0[$];
  logic [W-1:0] m_q1[$];
  logic [W-1:0] exp_q[$];
  int turn    = -1;
  int starve  = 0;
  bit e_valid = 0, e_next = 0, e_ovf0 = 0, e_ovf1 = 0, e_sync = 0;
  int e_err   = 0;

  // Reference model: applies the inputs present at each rising edge.
  always @(posedge clk_2f) begin : model
    int n0, n1, e;
    bit d0, d1;
    if (!reset) begin
      m_q0.delete();
      m_q1.delete();
      exp_q.delete();
      turn = -1; starve = 0;
      e_valid = 0; e_next = 0; e_ovf0 = 0; e_ovf1 = 0; e_sync = 0; e_err = 0;
    end else begin
      n0 = m_q0.size();
      n1 = m_q1.size();
      d0 = valid_0 && (n0 >= DEPTH);
      d1 = valid_1 && (n1 >= DEPTH);
      e_valid = 0;
      e_sync  = 0;
      if (turn < 0) begin
        starve = 0;
        if (n0 > 0 && n1 > 0) turn = 0;
      end else if (turn == 0 && n0 > 0) begin
        exp_q.push_back(m_q0.pop_front());
        e_valid = 1; starve = 0; turn = 1;
      end else if (turn == 1 && n1 > 0) begin
        exp_q.push_back(m_q1.pop_front());
        e_valid = 1; starve = 0; turn = 0;
      end else begin
        starve++;
        if (starve >= STALL_MAX) begin
          turn = -1; starve = 0; e_sync = 1;
        end
      end
      if (valid_0 && n0 < DEPTH) m_q0.push_back(lane_0);
      if (valid_1 && n1 < DEPTH) m_q1.push_back(lane_1);
      e_ovf0 = e_ovf0 | d0;
      e_ovf1 = e_ovf1 | d1;
      e_next = (turn == 1);
      e = e_err + int'(d0) + int'(d1) + int'(e_sync);
      e_err = (e > 255) ? 255 : e;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs half a cycle after each edge; data words are
  // taken from the scoreboard queue whenever the DUT presents one.
  always @(negedge clk_2f) begin : monitor
    logic [W-1:0] w;
    chk("valid_out", 32'(valid_out), 32'(e_valid));
    chk("next_lane", 32'(next_lane), 32'(e_next));
    chk("ovf_0", 32'(ovf_0), 32'(e_ovf0));
    chk("ovf_1", 32'(ovf_1), 32'(e_ovf1));
    chk("sync_err", 32'(sync_err), 32'(e_sync));
`ifdef UNSTRIPE_ERR_CNT_EN
    chk("err_cnt", 32'(err_cnt), 32'(e_err));
`endif
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", data_out, 32'hxxxx_xxxx);
      end else begin
        w = exp_q.pop_front();
        chk("data_out", data_out, w);
      end
    end
  end

  task automatic step(input bit r, input bit v0, input logic [W-1:0] d0,
                      input bit v1, input logic [W-1:0] d1);
    @(negedge clk_2f);
    reset = r; valid_0 = v0; lane_0 = d0; valid_1 = v1; lane_1 = d1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, '0, 1'b0, '0);
  endtask

  // Stimulus: directed scenarios, then random traffic with varying lane rates.
  initial begin : stim
    int p0, p1;
    reset = 1'b0; valid_0 = 1'b1; valid_1 = 1'b1;
    lane_0 = 32'h1234_5678; lane_1 = 32'h9ABC_DEF0;
    step(1'b0, 1'b1, 32'h5555_5555, 1'b1, 32'h6666_6666);
    idle(3);

    // Two pairs streamed back to back.
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hEEEE_EEEE);
    step(1'b1, 1'b1, 32'hDDDD_DDDD, 1'b1, 32'hCCCC_CCCC);
    idle(8);

    // Lane skew: lane 1 arrives one cycle ahead of lane 0.
    step(1'b1, 1'b0, '0, 1'b1, 32'hAAAA_AAAA);
    step(1'b1, 1'b1, 32'h1111_1111, 1'b0, '0);
    idle(6);

    // Lane 0 overflow while lane 1 is idle.
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, 32'(i), 1'b0, '0);
    idle(3);

    // Stream, then starve lane 1 while lane 0 trickles on.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, $urandom, 1'b1, $urandom);
    for (int i = 0; i < 14; i++) step(1'b1, (i % 4) == 0, $urandom, 1'b0, '0);
    idle(4);

    // Mid-operation reset with buffered words, then restart.
    step(1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, $urandom, 1'b1, $urandom);
    step(1'b0, 1'b1, $urandom, 1'b1, $urandom);
    step(1'b1, 1'b1, 32'h0BAD_F00D, 1'b1, 32'hC0FF_EE00);
    step(1'b1, 1'b1, 32'h0000_0007, 1'b1, 32'h0000_0008);
    idle(8);

    // Random traffic.
    p0 = 50; p1 = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        p0 = $urandom_range(0, 100);
        p1 = $urandom_range(0, 100);
      end
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 99) < p0), $urandom,
           ($urandom_range(0, 99) < p1), $urandom);
    end
    idle(20);
    chk("words_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unstriping_sched.md
Name: unstriping_sched

Overview:
Lane scheduler and reassembly controller for the two-lane un-striping path. It buffers words arriving on lane_0 and lane_1 in per-lane FIFOs and aligns the lanes at start-up. It then drains them in strict lane-0/lane-1 alternation onto a single output stream at clk_2f. It also detects lane overflow and lane stall, and re-synchronises after a stall.

Parameters:
WIDTH, 32, data width of each lane and of data_out.
DEPTH_LOG2, 2, log2 of the per-lane FIFO depth (DEPTH = 4 words).
STALL_MAX, 8, number of consecutive starved cycles in a RUN state before the block re-syncs.

Ports:
clk_2f  input  1  sole clock; all state changes on its rising edge.
reset  input  1  synchronous, active-low reset; sampled on clk_2f rising edge.
lane_0  input  WIDTH  lane 0 data word.
valid_0  input  1  lane_0 word present this cycle.
lane_1  input  WIDTH  lane 1 data word.
valid_1  input  1  lane_1 word present this cycle.
data_out  output  WIDTH  reassembled word (registered).
valid_out  output  1  data_out carries a new word this cycle (registered).
next_lane  output  1  lane the scheduler will pop next (0 or 1).
ovf_0  output  1  sticky: a lane 0 word was dropped.
ovf_1  output  1  sticky: a lane 1 word was dropped.
sync_err  output  1  one-cycle pulse when a stall timeout forces a re-sync.

Behaviour:
- Reset (reset==0 at an edge) takes effect at that edge:
  - data_out=0, valid_out=0, next_lane=0, ovf_0=0, ovf_1=0, sync_err=0.
  - Both FIFOs are emptied (pointers and counts cleared); the stall counter is cleared.
  - FSM state = SYNC.
  - Reset mid-operation discards all buffered words.
- FIFO write: if valid_x=1 and count_x<DEPTH, lane_x is written at the edge.
  - If count_x==DEPTH, the word is dropped and ovf_x is set. It stays set until reset.
  - A write is refused when the FIFO is full even if that FIFO is popped in the same cycle.
  - Simultaneous write and pop on a non-full FIFO is legal; the count is unchanged.
- A written word is visible at the FIFO head in the cycle after the write edge.
- FSM states:
  - SYNC: no pops, valid_out=0. When both FIFOs are non-empty, go to RUN_L0 at the next edge.
  - RUN_L0: if FIFO0 is non-empty, pop it, register its head into data_out, set valid_out=1, clear the stall counter, and go to RUN_L1. Otherwise valid_out=0, the stall counter increments, and the state holds.
  - RUN_L1: symmetric on FIFO1, returning to RUN_L0.
  - Stall timeout: in either RUN state, when the stall counter reaches STALL_MAX, go to SYNC and pulse sync_err for exactly one cycle. FIFO contents are kept, not flushed.
- next_lane = 1 only in RUN_L1; it is 0 in SYNC and RUN_L0.
- When valid_out=0, data_out holds its last value.
- Latency from SYNC: words written at edge N give SYNC exit at edge N+1 and the first pop (valid_out=1) at edge N+2. Streaming continues at one word per cycle while no lane starves.
- The stall counter saturates at STALL_MAX and is cleared on any pop or on entry to SYNC.

Optional Feature:
UNSTRIPE_ERR_CNT_EN
- Defined: adds output port err_cnt[7:0], reset to 0. It increments by 1 for each dropped word (per lane, so it can add 2 in one cycle) and for each sync_err pulse. It saturates at 255.
- Undefined: no err_cnt port and no counter logic; all other behaviour is identical.

Test Plan:
1. Hold reset=0 for 2 edges with valid_0=valid_1=1 -> all outputs 0, no FIFO writes, next_lane=0; after release the block is in SYNC.
2. Stream, with valid_x low after the second edge:
   - Edge N: lane_0=FFFFFFFF, lane_1=EEEEEEEE, both valid.
   - Edge N+1: DDDDDDDD and CCCCCCCC.
   - Required: valid_out=1 after edges N+2..N+5 with data_out=FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC, then valid_out=0.
3. Lane skew: only valid_1 with AAAAAAAA at edge N, only valid_0 with 11111111 at edge N+1 -> SYNC exit at edge N+2; outputs 11111111 at edge N+3 and AAAAAAAA at edge N+4.
4. Overflow: valid_0=1 for 6 edges with 00000001..00000006, valid_1=0 -> FIFO0 holds 01..04; ovf_0=1 after the 5th edge and stays 1; valid_out stays 0.
5. Stall: after scenario 2-style streaming, stop lane 1 while lane 0 continues -> after 8 starved cycles in RUN_L1, sync_err=1 for one cycle, state returns to SYNC, next_lane=0; with UNSTRIPE_ERR_CNT_EN defined, err_cnt increments.
6. Mid-operation reset: assert reset=0 while both FIFOs hold 3 words -> after that edge valid_out=0 and both FIFOs are empty; new pairs after release restart from lane 0 with the SYNC latency of scenario 2.
